// File: rtl/engine_power_ctrl_if.sv
// Engine power controller signal bundle.
// Every signal is a plain level; there is no valid/ready pairing. The master
// side (button/drive layer) drives the requests and the activity flag; the
// slave side (the controller) returns registered power, state and hold progress.
interface engine_power_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             power_on;
  logic             power_off;
  logic             manual_power;
  logic             activity;
  logic             next_power;
  logic [1:0]       state;
  logic [CNT_W-1:0] hold_ms;

  modport master (
    output power_on, power_off, manual_power, activity,
    input  next_power, state, hold_ms
  );

  modport slave (
    input  power_on, power_off, manual_power, activity,
    output next_power, state, hold_ms
  );
endinterface

// File: rtl/engine_power_ctrl.sv
// Engine power controller: qualifies a held power_on over ON_HOLD_MS ms ticks,
// latches engine power, drops it on power_off or on the manual_power rule, and
// parks in LOCK until power_on is released so a held button cannot re-arm.
// Optional macro AUTO_OFF_EN adds an idle timeout while powered (activity clears it).
// State encoding: 00 OFF, 01 ARM, 10 ON, 11 LOCK; state is exported as a debug/status output.
module engine_power_ctrl #(
  parameter int TICK_DIV        = 50000,
  parameter int ON_HOLD_MS      = 1000,
  parameter int IDLE_TIMEOUT_MS = 10000,
  parameter int CNT_W           = 16
) (
  input  logic                clk,
  input  logic                rst,
  engine_power_ctrl_if.slave  bus
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {
    S_OFF  = 2'b00,
    S_ARM  = 2'b01,
    S_ON   = 2'b10,
    S_LOCK = 2'b11
  } state_t;

  state_t           state_q;
  logic             power_q;
  logic [CNT_W-1:0] hold_q;
  logic [PW-1:0]    presc_q;
  logic             tick;

`ifdef AUTO_OFF_EN
  logic [CNT_W-1:0] idle_q;
`else
  // Activity and the idle timeout only matter when auto power-off is built in.
  localparam int unused_idle_timeout = IDLE_TIMEOUT_MS;
  logic unused_activity;
  assign unused_activity = bus.activity;
`endif

  // One-cycle ms tick on the last prescaler count.
  assign tick = (presc_q == PW'(TICK_DIV - 1));

  // Power state machine with registered power, hold progress and prescaler.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_OFF;
      power_q <= 1'b0;
      hold_q  <= '0;
      presc_q <= '0;
`ifdef AUTO_OFF_EN
      idle_q  <= '0;
`endif
    end else begin
      case (state_q)
        S_OFF: begin
          // power_off wins over a simultaneous power_on.
          if (bus.power_on && !bus.power_off) begin
            state_q <= S_ARM;
            hold_q  <= '0;
            presc_q <= '0;
          end
        end
        S_ARM: begin
          if (bus.power_off || !bus.power_on) begin
            state_q <= S_OFF;
            hold_q  <= '0;
            presc_q <= '0;
          end else if (tick) begin
            presc_q <= '0;
            // The tick that would make hold reach ON_HOLD_MS powers up instead,
            // so hold_ms never reaches the limit and never overflows.
            if (hold_q == CNT_W'(ON_HOLD_MS - 1)) begin
              state_q <= S_ON;
              power_q <= 1'b1;
              hold_q  <= '0;
`ifdef AUTO_OFF_EN
              idle_q  <= '0;
`endif
            end else begin
              hold_q <= hold_q + 1'b1;
            end
          end else begin
            presc_q <= presc_q + 1'b1;
          end
        end
        S_ON: begin
          if (bus.power_off || (!bus.manual_power && !bus.power_on)) begin
            state_q <= S_LOCK;
            power_q <= 1'b0;
            presc_q <= '0;
          end else begin
            presc_q <= tick ? '0 : presc_q + 1'b1;
`ifdef AUTO_OFF_EN
            if (bus.activity) begin
              idle_q <= '0;
            end else if (tick) begin
              if (idle_q == CNT_W'(IDLE_TIMEOUT_MS - 1)) begin
                state_q <= S_LOCK;
                power_q <= 1'b0;
                presc_q <= '0;
                idle_q  <= '0;
              end else begin
                idle_q <= idle_q + 1'b1;
              end
            end
`endif
          end
        end
        S_LOCK: begin
          // Only a released power_on lets the controller re-arm later.
          if (!bus.power_on) begin
            state_q <= S_OFF;
          end
        end
        default: begin
          state_q <= S_OFF;
          power_q <= 1'b0;
          hold_q  <= '0;
          presc_q <= '0;
        end
      endcase
    end
  end

  assign bus.next_power = power_q;
  assign bus.state      = state_q;
  assign bus.hold_ms    = hold_q;

endmodule

// File: tb/tb_engine_power_ctrl.sv
// Directed bench for engine_power_ctrl with TICK_DIV=4, ON_HOLD_MS=5,
// IDLE_TIMEOUT_MS=8. Inputs change 1 time unit after a rising edge and
// outputs are sampled there too, well away from the next active edge.
module tb_engine_power_ctrl;

  localparam int TICK_DIV = 4;
  localparam int ON_HOLD  = 5;
  localparam int IDLE_TO  = 8;
  localparam int CNT_W    = 16;

  localparam logic [1:0] ST_OFF  = 2'b00;
  localparam logic [1:0] ST_ARM  = 2'b01;
  localparam logic [1:0] ST_ON   = 2'b10;
  localparam logic [1:0] ST_LOCK = 2'b11;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  engine_power_ctrl_if #(.CNT_W(CNT_W)) bus ();

  engine_power_ctrl #(
    .TICK_DIV        (TICK_DIV),
    .ON_HOLD_MS      (ON_HOLD),
    .IDLE_TIMEOUT_MS (IDLE_TO),
    .CNT_W           (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Clock: period 10, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [1:0] st, input logic np,
                            input logic [CNT_W-1:0] hm);
    check({tag, ".state"}, 32'(bus.state), 32'(st));
    check({tag, ".power"}, 32'(bus.next_power), 32'(np));
    check({tag, ".hold"},  32'(bus.hold_ms), 32'(hm));
  endtask

  // From OFF: hold power_on until the controller powers up (20 + 1 edges).
  task automatic go_on(input string tag);
    bus.power_on = 1'b1;
    step(ON_HOLD * TICK_DIV + 1);
    check_outs(tag, ST_ON, 1'b1, '0);
  endtask

  // From ON: power_off with power_on released, then back to OFF.
  task automatic shut_down(input string tag);
    bus.power_off = 1'b1;
    bus.power_on  = 1'b0;
    step(1);
    check_outs({tag, ".lock"}, ST_LOCK, 1'b0, '0);
    bus.power_off = 1'b0;
    step(1);
    check_outs({tag, ".off"}, ST_OFF, 1'b0, '0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst              = 1'b0;
    bus.power_on     = 1'b0;
    bus.power_off    = 1'b0;
    bus.manual_power = 1'b1;
    bus.activity     = 1'b0;

    // Reset state.
    #1;
    check_outs("reset", ST_OFF, 1'b0, '0);
    #11 rst = 1'b1;
    step(1);
    check_outs("post_reset", ST_OFF, 1'b0, '0);

    // 1: held power_on arms on the first edge and powers up 20 edges later.
    bus.power_on = 1'b1;
    step(1);
    check_outs("t1.arm", ST_ARM, 1'b0, 16'd0);
    step(4);
    check_outs("t1.tick1", ST_ARM, 1'b0, 16'd1);
    step(15);
    check_outs("t1.edge20", ST_ARM, 1'b0, 16'd4);
    step(1);
    check_outs("t1.edge21", ST_ON, 1'b1, 16'd0);

    // 3: power_off pulse with power_on held -> LOCK until power_on released.
    bus.power_off = 1'b1;
    step(1);
    check_outs("t3.lock", ST_LOCK, 1'b0, '0);
    bus.power_off = 1'b0;
    step(2);
    check_outs("t3.held", ST_LOCK, 1'b0, '0);
    bus.power_on = 1'b0;
    step(1);
    check_outs("t3.off", ST_OFF, 1'b0, '0);
    bus.power_on = 1'b1;
    step(1);
    check_outs("t3.rearm", ST_ARM, 1'b0, 16'd0);

    // 2: power_on held 12 edges in total then dropped -> back to OFF.
    step(9);
    check_outs("t2.hold2", ST_ARM, 1'b0, 16'd2);
    step(2);
    bus.power_on = 1'b0;
    step(1);
    check_outs("t2.off", ST_OFF, 1'b0, '0);
    step(3);
    check_outs("t2.stay", ST_OFF, 1'b0, '0);

    // 4: manual_power=0 keeps ON only while power_on is held.
    go_on("t4.on");
    bus.manual_power = 1'b0;
    step(3);
    check_outs("t4.held", ST_ON, 1'b1, '0);
    bus.power_on = 1'b0;
    step(1);
    check_outs("t4.lock", ST_LOCK, 1'b0, '0);
    step(1);
    check_outs("t4.off", ST_OFF, 1'b0, '0);
    bus.manual_power = 1'b1;

    // manual_power=1: released power_on keeps the engine on.
    go_on("t4b.on");
    bus.power_on = 1'b0;
    step(5);
    check_outs("t4b.manual", ST_ON, 1'b1, '0);

`ifndef AUTO_OFF_EN
    // Without auto power-off, long inactivity changes nothing.
    step(40);
    check_outs("t5.no_idle", ST_ON, 1'b1, '0);
    shut_down("t5.sd");
`else
    shut_down("t5.sd0");
    // 5: 32 idle edges after ON entry -> LOCK.
    go_on("t5.on");
    bus.power_on = 1'b0;
    step(31);
    check_outs("t5.idle31", ST_ON, 1'b1, '0);
    step(1);
    check_outs("t5.idle32", ST_LOCK, 1'b0, '0);
    step(1);
    check_outs("t5.off", ST_OFF, 1'b0, '0);
    // Activity pulse on edge 28 restarts the count; LOCK 32 edges later.
    go_on("t5b.on");
    bus.power_on = 1'b0;
    step(27);
    bus.activity = 1'b1;
    step(1);
    bus.activity = 1'b0;
    step(31);
    check_outs("t5b.after31", ST_ON, 1'b1, '0);
    step(1);
    check_outs("t5b.after32", ST_LOCK, 1'b0, '0);
    step(1);
`endif

    // 6: asynchronous reset mid-ARM clears outputs before the next edge.
    bus.power_on = 1'b1;
    step(1);
    check_outs("t6.arm", ST_ARM, 1'b0, 16'd0);
    step(12);
    check_outs("t6.hold3", ST_ARM, 1'b0, 16'd3);
    #2 rst = 1'b0;
    #1;
    check_outs("t6.async", ST_OFF, 1'b0, '0);
    #2 rst = 1'b1;
    bus.power_off = 1'b1;
    step(3);
    check_outs("t6.both", ST_OFF, 1'b0, '0);
    bus.power_off = 1'b0;
    step(1);
    check_outs("t6.rearm", ST_ARM, 1'b0, 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
